// File: rtl/peridot_board_romreader_if.sv
// peridot_board_romreader_if: ROM byte-read bus plus the request/status
// signals of the PERIDOT board ROM reader. The reader is the master: it
// drives the byte address and the result, the ROM side/host drives the
// data, readiness and the start request.
interface peridot_board_romreader_if;
  logic        rom_ready;
  logic [4:0]  byteaddr;
  logic [7:0]  bytedata;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] uid;
  logic        uid_valid;
  logic [7:0]  gencode;
  logic        error;
  logic [1:0]  err_code;

  modport master (
    input  rom_ready, bytedata, start,
    output byteaddr, busy, done, uid, uid_valid, gencode, error, err_code
  );

  modport slave (
    output rom_ready, bytedata, start,
    input  byteaddr, busy, done, uid, uid_valid, gencode, error, err_code
  );
endinterface

// File: rtl/peridot_board_romreader.sv
// peridot_board_romreader: walks the 26-byte PERIDOT board ROM (10 header
// bytes, 16 ASCII-hex UID characters) over a byte-read bus with a fixed
// READ_LATENCY, validates the header and decodes the UID to 64 bits.
// Optional feature: define PERIDOT_ROMREADER_TIMEOUT_EN to give up waiting
// for rom_ready after TIMEOUT_CYCLES idle-ready cycles (err_code 3).
module peridot_board_romreader #(
  parameter logic [7:0] EXPECT_GENCODE = 8'h4e,
  parameter int         READ_LATENCY   = 1,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input logic                       clk,
  input logic                       reset,
  peridot_board_romreader_if.master bus
);

  // Reject parameter values the counters cannot represent.
  if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
    $error("peridot_board_romreader: READ_LATENCY must be 0..3");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("peridot_board_romreader: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [1:0] {IDLE, WAIT_READY, FETCH, DONE} state_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);
  localparam logic [4:0] LAST_HDR = 5'd9;
  localparam logic [4:0] LAST_IDX = 5'd25;

  state_t      state;
  logic [4:0]  byte_idx;
  logic [1:0]  lat_cnt;
  // Only the low 60 bits of the 64-bit shift can survive into the final
  // value (the last nibble is appended on the way into uid_r).
  logic [59:0] shift_r;
  logic [63:0] uid_r;
  logic        uid_valid_r;
  logic [7:0]  gencode_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic [1:0]  err_code_r;
  logic [7:0]  data;
  logic        hdr_ok;
  logic        hex_ok;
  logic [3:0]  hex_nib;

`ifdef PERIDOT_ROMREADER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt;
`endif

  assign data = bus.bytedata;

  // Header byte comparison for the current index; byte 7 is the generation
  // code, which may be a wildcard when EXPECT_GENCODE is zero.
  always_comb begin
    hdr_ok = 1'b0;
    case (byte_idx)
      5'd0:    hdr_ok = (data == 8'h4a);
      5'd1:    hdr_ok = (data == 8'h37);
      5'd2:    hdr_ok = (data == 8'h57);
      5'd3:    hdr_ok = (data == 8'h02);
      5'd4:    hdr_ok = (data == 8'h4a);
      5'd5:    hdr_ok = (data == 8'h37);
      5'd6:    hdr_ok = (data == 8'h32);
      5'd7:    hdr_ok = (EXPECT_GENCODE == 8'h00) || (data == EXPECT_GENCODE);
      5'd8:    hdr_ok = (data == 8'h39);
      5'd9:    hdr_ok = (data == 8'h33);
      default: hdr_ok = 1'b0;
    endcase
  end

  // Upper-case ASCII hex to nibble; anything else (including lower case) is rejected.
  always_comb begin
    hex_ok  = 1'b1;
    hex_nib = data[3:0];
    if (data >= 8'h30 && data <= 8'h39) begin
      hex_nib = data[3:0];
    end else if (data >= 8'h41 && data <= 8'h46) begin
      hex_nib = data[3:0] + 4'd9;
    end else begin
      hex_ok  = 1'b0;
      hex_nib = 4'd0;
    end
  end

  // Read sequencer: request acceptance, ready wait, byte walk with header
  // and hex checks, and the one-cycle completion state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_idx    <= 5'd0;
      lat_cnt     <= 2'd0;
      shift_r     <= '0;
      uid_r       <= '0;
      uid_valid_r <= 1'b0;
      gencode_r   <= 8'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      err_code_r  <= 2'd0;
`ifdef PERIDOT_ROMREADER_TIMEOUT_EN
      wait_cnt    <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state       <= WAIT_READY;
            busy_r      <= 1'b1;
            uid_valid_r <= 1'b0;
            error_r     <= 1'b0;
            err_code_r  <= 2'd0;
            byte_idx    <= 5'd0;
            lat_cnt     <= 2'd0;
            shift_r     <= '0;
`ifdef PERIDOT_ROMREADER_TIMEOUT_EN
            wait_cnt    <= 16'd0;
`endif
          end
        end

        WAIT_READY: begin
          if (bus.rom_ready) begin
            state <= FETCH;
          end
`ifdef PERIDOT_ROMREADER_TIMEOUT_EN
          else if (wait_cnt == TMO_LIMIT) begin
            err_code_r <= 2'd3;
            error_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end

        FETCH: begin
          if (lat_cnt != LAT_LAST) begin
            lat_cnt <= lat_cnt + 2'd1;
          end else begin
            lat_cnt <= 2'd0;
            if (byte_idx <= LAST_HDR) begin
              if (byte_idx == 5'd7) begin
                gencode_r <= data;
              end
              if (!hdr_ok) begin
                err_code_r <= 2'd1;
                error_r    <= 1'b1;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
                state      <= DONE;
              end else begin
                byte_idx <= byte_idx + 5'd1;
              end
            end else if (!hex_ok) begin
              err_code_r <= 2'd2;
              error_r    <= 1'b1;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state      <= DONE;
            end else begin
              shift_r <= {shift_r[55:0], hex_nib};
              if (byte_idx == LAST_IDX) begin
                uid_r       <= {shift_r, hex_nib};
                uid_valid_r <= 1'b1;
                busy_r      <= 1'b0;
                done_r      <= 1'b1;
                state       <= DONE;
              end else begin
                byte_idx <= byte_idx + 5'd1;
              end
            end
          end
        end

        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byteaddr  = byte_idx;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.uid       = uid_r;
  assign bus.uid_valid = uid_valid_r;
  assign bus.gencode   = gencode_r;
  assign bus.error     = error_r;
  assign bus.err_code  = err_code_r;

endmodule

// File: tb/tb_peridot_board_romreader.sv
// tb_peridot_board_romreader: two readers share one ROM image. dut_a uses
// READ_LATENCY=1 with gencode 4e required, dut_b uses READ_LATENCY=0 with
// any gencode accepted. Expected results come from a byte-walk model of the
// ROM rules and are queued per reader; a monitor per reader checks each done.
module tb_peridot_board_romreader;

  localparam int TMO = 16;
  localparam logic [7:0] HDR [10] = '{8'h4a, 8'h37, 8'h57, 8'h02, 8'h4a,
                                      8'h37, 8'h32, 8'h00, 8'h39, 8'h33};

  typedef struct packed {
    logic [1:0]  err;
    logic [63:0] uid;
    logic        uid_valid;
    logic [7:0]  gen;
    logic [4:0]  addr;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  rom [0:31];
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        e_a, e_b;
  logic [63:0] last_uid_a, last_uid_b;
  logic [7:0]  last_gen_a, last_gen_b;
  bit          post_a, post_b;
  logic        post_err_a, post_err_b;

  peridot_board_romreader_if ifa ();
  peridot_board_romreader_if ifb ();

  peridot_board_romreader #(
    .EXPECT_GENCODE(8'h4e), .READ_LATENCY(1), .TIMEOUT_CYCLES(TMO)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  peridot_board_romreader #(
    .EXPECT_GENCODE(8'h00), .READ_LATENCY(0), .TIMEOUT_CYCLES(TMO)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM models: one-cycle registered read for dut_a, combinational for dut_b.
  always @(posedge clk) ifa.bytedata <= rom[ifa.byteaddr];
  assign ifb.bytedata = rom[ifb.byteaddr];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic compareDone(input string tag, input exp_t e, input int now,
                             input logic [1:0] code, input logic err, input logic [63:0] u,
                             input logic uv, input logic [7:0] g, input logic [4:0] addr,
                             input logic bsy);
    checkOutput({tag, " err_code"}, 64'(code), 64'(e.err));
    checkOutput({tag, " error"}, 64'(err), 64'(e.err != 2'd0));
    checkOutput({tag, " uid"}, u, e.uid);
    checkOutput({tag, " uid_valid"}, 64'(uv), 64'(e.uid_valid));
    checkOutput({tag, " gencode"}, 64'(g), 64'(e.gen));
    checkOutput({tag, " byteaddr"}, 64'(addr), 64'(e.addr));
    checkOutput({tag, " done cycle"}, 64'(now), 64'(e.done_cyc));
    checkOutput({tag, " busy at done"}, 64'(bsy), 64'd0);
  endtask

  task automatic checkReset(input string tag, input logic [4:0] addr, input logic bsy,
                            input logic dn, input logic [63:0] u, input logic uv,
                            input logic [7:0] g, input logic err, input logic [1:0] code);
    checkOutput({tag, " reset byteaddr"}, 64'(addr), 64'd0);
    checkOutput({tag, " reset busy"}, 64'(bsy), 64'd0);
    checkOutput({tag, " reset done"}, 64'(dn), 64'd0);
    checkOutput({tag, " reset uid"}, u, 64'd0);
    checkOutput({tag, " reset uid_valid"}, 64'(uv), 64'd0);
    checkOutput({tag, " reset gencode"}, 64'(g), 64'd0);
    checkOutput({tag, " reset error"}, 64'(err), 64'd0);
    checkOutput({tag, " reset err_code"}, 64'(code), 64'd0);
  endtask

  // Reference model: walk the ROM image byte by byte using the board ROM
  // rules; each byte costs lat+1 cycles once the ready wait is over.
  function automatic exp_t predict(input int lat, input logic [7:0] expect_gen,
                                   input int ready_delay, input int start_cyc,
                                   input logic [63:0] prev_uid, input logic [7:0] prev_gen);
    exp_t        e;
    logic [63:0] acc;
    int          nib;
    acc         = 64'd0;
    e.err       = 2'd0;
    e.uid       = prev_uid;
    e.uid_valid = 1'b0;
    e.gen       = prev_gen;
    e.addr      = 5'd0;
    e.done_cyc  = 0;
`ifdef PERIDOT_ROMREADER_TIMEOUT_EN
    if (ready_delay > TMO) begin
      e.err      = 2'd3;
      e.done_cyc = start_cyc + TMO + 2;
      return e;
    end
`endif
    for (int j = 0; j < 26; j++) begin
      e.addr     = 5'(j);
      e.done_cyc = start_cyc + 2 + ready_delay + (j + 1) * (lat + 1);
      if (j < 10) begin
        if (j == 7) begin
          e.gen = rom[j];
          if (expect_gen != 8'h00 && rom[j] != expect_gen) begin
            e.err = 2'd1;
            return e;
          end
        end else if (rom[j] != HDR[j]) begin
          e.err = 2'd1;
          return e;
        end
      end else begin
        if (rom[j] >= 8'h30 && rom[j] <= 8'h39) nib = int'(rom[j]) - 48;
        else if (rom[j] >= 8'h41 && rom[j] <= 8'h46) nib = int'(rom[j]) - 65 + 10;
        else begin
          e.err = 2'd2;
          return e;
        end
        acc = acc * 64'd16 + 64'(nib);
      end
    end
    e.uid       = acc;
    e.uid_valid = 1'b1;
    return e;
  endfunction

  task automatic buildImage(input logic [63:0] u, input logic [7:0] g);
    logic [3:0] n;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    for (int i = 0; i < 10; i++) rom[i] = HDR[i];
    rom[7] = g;
    for (int i = 0; i < 16; i++) begin
      n = u[63 - 4 * i -: 4];
      rom[10 + i] = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    end
  endtask

  // Issue one read to both readers, queue both predictions, then hold
  // rom_ready low for ready_delay wait cycles and wait for both completions.
  task automatic applyStimulus(input int ready_delay, input bit noisy);
    int k;
    int limit;
    bit tmo_exp;
    exp_t ea, eb;
    tmo_exp = 1'b0;
`ifdef PERIDOT_ROMREADER_TIMEOUT_EN
    tmo_exp = (ready_delay > TMO);
`endif
    @(negedge clk);
    ea = predict(1, 8'h4e, ready_delay, cyc, last_uid_a, last_gen_a);
    eb = predict(0, 8'h00, ready_delay, cyc, last_uid_b, last_gen_b);
    last_uid_a = ea.uid; last_gen_a = ea.gen;
    last_uid_b = eb.uid; last_gen_b = eb.gen;
    qa.push_back(ea);
    qb.push_back(eb);
    ifa.start = 1'b1; ifb.start = 1'b1;
    ifa.rom_ready = (ready_delay == 0);
    ifb.rom_ready = (ready_delay == 0);
    @(negedge clk);
    k = 1;
    limit = ready_delay + 80;
    while ((qa.size() != 0 || qb.size() != 0) && k < limit) begin
      ifa.rom_ready = (k >= ready_delay + 1);
      ifb.rom_ready = (k >= ready_delay + 1);
      ifa.start = noisy && ifa.busy && ($urandom_range(0, 3) == 0);
      ifb.start = noisy && ifb.busy && ($urandom_range(0, 3) == 0);
      if (ready_delay >= 100 && !tmo_exp && k == ready_delay) begin
        checkOutput("A busy during ready wait", 64'(ifa.busy), 64'd1);
        checkOutput("B busy during ready wait", 64'(ifb.busy), 64'd1);
      end
      @(negedge clk);
      k++;
    end
    ifa.start = 1'b0; ifb.start = 1'b0;
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done wait: actual pending=%0d/%0d required 0/0 within %0d cycles",
               qa.size(), qb.size(), limit);
      qa.delete();
      qb.delete();
    end
  endtask

  // Monitor for dut_a: check each completion and the cycle after it.
  always @(negedge clk) begin
    if (reset) begin
      post_a = 1'b0;
    end else begin
      if (post_a) begin
        checkOutput("A done pulse width", 64'(ifa.done), 64'd0);
        checkOutput("A error hold", 64'(ifa.error), 64'(post_err_a));
        post_a = 1'b0;
      end
      if (ifa.done) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL A unexpected done: actual done=1 required no pending read");
        end else begin
          e_a = qa.pop_front();
          compareDone("A", e_a, cyc, ifa.err_code, ifa.error, ifa.uid, ifa.uid_valid,
                      ifa.gencode, ifa.byteaddr, ifa.busy);
          post_a = 1'b1;
          post_err_a = (e_a.err != 2'd0);
        end
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (reset) begin
      post_b = 1'b0;
    end else begin
      if (post_b) begin
        checkOutput("B done pulse width", 64'(ifb.done), 64'd0);
        checkOutput("B error hold", 64'(ifb.error), 64'(post_err_b));
        post_b = 1'b0;
      end
      if (ifb.done) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL B unexpected done: actual done=1 required no pending read");
        end else begin
          e_b = qb.pop_front();
          compareDone("B", e_b, cyc, ifb.err_code, ifb.error, ifb.uid, ifb.uid_valid,
                      ifb.gencode, ifb.byteaddr, ifb.busy);
          post_b = 1'b1;
          post_err_b = (e_b.err != 2'd0);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] u;
    logic [7:0]  g;
    int          guard;
    int          sel;
    int          pos;
    logic [7:0]  bad [7];
    bad = '{8'h67, 8'h2f, 8'h3a, 8'h40, 8'h47, 8'h61, 8'h00};

    reset = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    ifa.rom_ready = 1'b0; ifb.rom_ready = 1'b0;
    last_uid_a = 64'd0; last_uid_b = 64'd0;
    last_gen_a = 8'h00; last_gen_b = 8'h00;
    buildImage(64'h0123456789abcdef, 8'h4e);
    repeat (3) @(negedge clk);
    checkReset("A", ifa.byteaddr, ifa.busy, ifa.done, ifa.uid, ifa.uid_valid,
               ifa.gencode, ifa.error, ifa.err_code);
    checkReset("B", ifb.byteaddr, ifb.busy, ifb.done, ifb.uid, ifb.uid_valid,
               ifb.gencode, ifb.error, ifb.err_code);
    reset = 1'b0;

    $display("[TB] good image, ready immediately");
    applyStimulus(0, 1'b0);

    $display("[TB] generation code 41");
    buildImage(64'h0123456789abcdef, 8'h41);
    applyStimulus(0, 1'b0);

    $display("[TB] non-hex character at byte 13");
    buildImage(64'h0123456789abcdef, 8'h4e);
    rom[13] = 8'h67;
    applyStimulus(0, 1'b0);

    $display("[TB] rom_ready late by 200 cycles with start noise");
    buildImage(64'hfedcba9876543210, 8'h4e);
    applyStimulus(200, 1'b1);

    $display("[TB] rom_ready stuck low for 1100 cycles");
    buildImage(64'h00ff00ff12345678, 8'h4e);
    applyStimulus(1100, 1'b0);

    $display("[TB] reset during fetch");
    buildImage(64'h0123456789abcdef, 8'h4e);
    @(negedge clk);
    qa.push_back(predict(1, 8'h4e, 0, cyc, last_uid_a, last_gen_a));
    qb.push_back(predict(0, 8'h00, 0, cyc, last_uid_b, last_gen_b));
    ifa.start = 1'b1; ifb.start = 1'b1;
    ifa.rom_ready = 1'b1; ifb.rom_ready = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0;
    guard = 0;
    while (ifa.byteaddr != 5'd15 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("A reaches byte 15", 64'(ifa.byteaddr), 64'd15);
    reset = 1'b1;
    @(negedge clk);
    checkReset("A mid", ifa.byteaddr, ifa.busy, ifa.done, ifa.uid, ifa.uid_valid,
               ifa.gencode, ifa.error, ifa.err_code);
    checkReset("B mid", ifb.byteaddr, ifb.busy, ifb.done, ifb.uid, ifb.uid_valid,
               ifb.gencode, ifb.error, ifb.err_code);
    reset = 1'b0;
    qa.delete();
    qb.delete();
    last_uid_a = 64'd0; last_uid_b = 64'd0;
    last_gen_a = 8'h00; last_gen_b = 8'h00;
    applyStimulus(1, 1'b0);

    $display("[TB] randomized images");
    for (int t = 0; t < 40; t++) begin
      u = {$urandom, $urandom};
      g = ($urandom_range(0, 1) == 0) ? 8'h4e : 8'($urandom_range(0, 255));
      buildImage(u, g);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        pos = $urandom_range(0, 9);
        rom[pos] = rom[pos] ^ 8'($urandom_range(1, 255));
      end else if (sel == 1) begin
        pos = $urandom_range(10, 25);
        rom[pos] = bad[$urandom_range(0, 6)];
      end
      applyStimulus($urandom_range(0, 4), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
